// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix operand datapath.
package matrix_pkg;

    localparam int DEF_MATRIX_SIZE = 3;
    localparam int DEF_WORD_LENGTH = 8;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Index width for a counter over n positions; a 1x1 matrix still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Element stream handshake into the loader: producer drives data/valid, loader drives ready.
interface matrix_stream_loader_if
    import matrix_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH
);
    logic [WORD_LENGTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker over a MATRIX_SIZE x MATRIX_SIZE grid; last flags the final cell.
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    localparam int IW = idx_w(MATRIX_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clear,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic          last
);
    localparam logic [IW-1:0] MAXI = IW'(MATRIX_SIZE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == MAXI) begin
                col <= '0;
                row <= (row == MAXI) ? '0 : row + IW'(1);
            end else begin
                col <= col + IW'(1);
            end
        end
    end

    assign last = (row == MAXI) && (col == MAXI);
endmodule

// File: rtl/matrix_stream_loader.sv
// Loads two square operand matrices from an element stream and holds them until acknowledged.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] A,
    output logic [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1][WORD_LENGTH-1:0] B,
    output logic                   mat_valid,
    input  logic                   mat_ack
);
    localparam int IW = idx_w(MATRIX_SIZE);

    state_t        state_q, state_d;
    logic [IW-1:0] row, col;
    logic          last, xfer, wr_en;

    assign xfer  = in_valid && in_ready;
    // Flush wins over a coincident transfer: the element is dropped.
    assign wr_en = xfer && !flush;

    matrix_index_counter #(.MATRIX_SIZE(MATRIX_SIZE)) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (wr_en),
        .clear   (flush),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A:  if (xfer && last) state_d = LOAD_B;
                LOAD_B:  if (xfer && last) state_d = HOLD;
                HOLD:    if (mat_ack)      state_d = LOAD_A;
                default:                   state_d = LOAD_A;
            endcase
        end
    end

    // Handshake outputs depend on state alone so in_ready never combinationally follows in_valid.
    always_comb begin
        in_ready  = (state_q != HOLD);
        mat_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A <= '0;
            B <= '0;
        end else if (wr_en) begin
            if (state_q == LOAD_A)      A[row][col] <= in_data;
            else if (state_q == LOAD_B) B[row][col] <= in_data;
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench: a count-based model pushes accepted elements to a queue, popped when the pair is held.
module tb_matrix_stream_loader;
    localparam int N  = 3;
    localparam int WL = 8;
    localparam int NE = 2 * N * N;

    typedef logic [0:N-1][0:N-1][WL-1:0] mat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush, mat_ack;
    mat_t A, B;
    logic mat_valid;

    logic [WL-1:0]       d1;
    logic                v1, r1, f1, ack1, mv1;
    logic [0:0][0:0][WL-1:0] A1, B1;

    int nchk = 0;
    int nfail = 0;
    int mcnt = 0;
    logic [WL-1:0] exp_q[$];
    mat_t expA, expB;

    always #5 clk = ~clk;

    matrix_stream_loader_if #(.WORD_LENGTH(WL)) s ();

    matrix_stream_loader #(.MATRIX_SIZE(N), .WORD_LENGTH(WL)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(s.in_data), .in_valid(s.in_valid),
        .in_ready(s.in_ready), .flush(flush), .A(A), .B(B),
        .mat_valid(mat_valid), .mat_ack(mat_ack)
    );

    matrix_stream_loader #(.MATRIX_SIZE(1), .WORD_LENGTH(WL)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .flush(f1), .A(A1), .B(B1), .mat_valid(mv1), .mat_ack(ack1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pair();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) expA[r][c] = exp_q.pop_front();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) expB[r][c] = exp_q.pop_front();
        chk("pair_A", A, expA);
        chk("pair_B", B, expB);
    endtask

    // One clock of stimulus; the model decides acceptance from its own element count.
    task automatic cyc(input logic [WL-1:0] d, input bit v, input bit f, input bit ack);
        s.in_data = d; s.in_valid = v; flush = f; mat_ack = ack;
        if (f) begin
            mcnt = 0;
            exp_q.delete();
        end else if (mcnt < NE && v) begin
            exp_q.push_back(d);
            mcnt++;
        end else if (mcnt == NE && ack) begin
            mcnt = 0;
        end
        @(posedge clk); #1;
        chk("in_ready", s.in_ready, mcnt < NE);
        chk("mat_valid", mat_valid, mcnt == NE);
        if (mcnt == NE && exp_q.size() == NE) check_pair();
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; mat_ack = 0; s.in_data = '0; s.in_valid = 0;
        d1 = '0; v1 = 0; f1 = 0; ack1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", s.in_ready, 1'b1);
        chk("rst_mat_valid", mat_valid, 1'b0);
        chk("rst_A", A, '0);
        chk("rst_B", B, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", s.in_ready, 1'b1);

        // Continuous stream 1..18
        for (int i = 1; i <= NE; i++) cyc(WL'(i), 1, 0, 0);

        // Held pair stays put while the producer keeps pushing
        for (int i = 0; i < 10; i++) begin
            cyc(8'hEE, 1, 0, 0);
            chk("hold_A", A, expA);
            chk("hold_B", B, expB);
        end
        cyc(8'h00, 0, 0, 1);
        cyc(8'd99, 1, 0, 0);
        chk("ack_A00", A[0][0], 8'd99);
        chk("ack_A01_kept", A[0][1], 8'd2);
        chk("ack_B22_kept", B[2][2], 8'd18);

        // Toggled valid with junk data on idle cycles
        cyc(8'h00, 0, 1, 0);
        for (int i = 1; i <= NE; i++) begin
            cyc(WL'(i), 1, 0, 0);
            cyc(8'hFF, 0, 0, 0);
        end
        cyc(8'h00, 0, 0, 1);

        // Flush on the 5th B transfer
        for (int i = 1; i <= N * N + 4; i++) cyc(WL'(50 + i), 1, 0, 0);
        cyc(8'd77, 1, 1, 0);
        chk("flush_B11_kept", B[1][1], 8'd14);
        chk("flush_B10", B[1][0], 8'd63);
        for (int i = 1; i <= NE; i++) cyc(WL'(100 + i), 1, 0, 0);
        chk("reload_A00", A[0][0], 8'd101);

        // Flush and ack together in HOLD
        cyc(8'h00, 0, 1, 1);
        cyc(8'd44, 1, 0, 0);
        chk("flush_ack_A00", A[0][0], 8'd44);

        // Asynchronous reset mid-load
        cyc(8'h00, 0, 1, 0);
        for (int i = 1; i <= 7; i++) cyc(WL'(200 + i), 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_A", A, '0);
        chk("arst_B", B, '0);
        chk("arst_in_ready", s.in_ready, 1'b1);
        chk("arst_mat_valid", mat_valid, 1'b0);
        mcnt = 0;
        exp_q.delete();
        s.in_valid = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(8'd33, 1, 0, 0);
        chk("arst_first_A00", A[0][0], 8'd33);
        chk("arst_first_A01", A[0][1], 8'd0);

        // 1x1 build
        d1 = 8'd5; v1 = 1;
        @(posedge clk); #1;
        chk("n1_mv_after_A", mv1, 1'b0);
        chk("n1_A", A1, 8'd5);
        d1 = 8'd7;
        @(posedge clk); #1;
        v1 = 0;
        chk("n1_mv", mv1, 1'b1);
        chk("n1_ready", r1, 1'b0);
        chk("n1_B", B1, 8'd7);
        chk("n1_A_kept", A1, 8'd5);
        ack1 = 1;
        @(posedge clk); #1;
        ack1 = 0;
        chk("n1_ack_ready", r1, 1'b1);
        chk("n1_ack_mv", mv1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/matrix_stream_loader.md
MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 3, the number of rows and columns of each square matrix.
REQ-002 SHALL have parameter WORD_LENGTH, default 8, the bit width of each element.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_data  input  WORD_LENGTH  incoming element.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-008 SHALL have port flush  input  1  synchronous abort of the current load.
REQ-009 SHALL have port A  output  WORD_LENGTH x [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1]  left operand, registered.
REQ-010 SHALL have port B  output  WORD_LENGTH x [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1]  right operand, registered.
REQ-011 SHALL have port mat_valid  output  1  A and B hold a complete operand pair.
REQ-012 SHALL have port mat_ack  input  1  consumer has taken the pair.

Function
REQ-013 SHALL treat a transfer as in_valid AND in_ready high at a rising clk edge.
REQ-014 SHALL implement states LOAD_A, LOAD_B, HOLD.
REQ-015 SHALL drive in_ready high in LOAD_A and LOAD_B and low in HOLD, decoded from state only, with no dependence on in_valid.
REQ-016 SHALL drive mat_valid high in HOLD only, decoded from state only.
REQ-017 SHALL write each transferred element to A[row][col] in LOAD_A and to B[row][col] in LOAD_B, in row-major order with col incrementing fastest.
REQ-018 SHALL on a transfer with col = MATRIX_SIZE-1 wrap col to 0 and increment row.
REQ-019 SHALL on a transfer with row = col = MATRIX_SIZE-1 wrap row and col to 0 and advance LOAD_A to LOAD_B, or LOAD_B to HOLD.
REQ-020 SHALL, when the last B element transfers at edge N, present mat_valid high from edge N onward; latency from the last element to mat_valid is one cycle.
REQ-021 SHALL hold A, B and mat_valid stable in HOLD until mat_ack is sampled high.
REQ-022 SHALL on mat_ack in HOLD move to LOAD_A with row = col = 0, and assert in_ready in the following cycle.
REQ-023 SHALL ignore mat_ack outside HOLD.
REQ-024 SHALL leave A and B contents unchanged on leaving HOLD; elements are overwritten only by new transfers.
REQ-025 SHALL on flush high return to LOAD_A with row = col = 0 from any state, and leave A and B unchanged.
REQ-026 SHALL give flush priority when flush and a transfer occur on the same edge; the element is discarded.
REQ-027 SHALL give flush priority when flush and mat_ack occur together in HOLD; the result is identical (LOAD_A).
REQ-028 SHALL size the row and col counters as $clog2(MATRIX_SIZE), minimum 1 bit, and never index beyond MATRIX_SIZE-1.

Reset
REQ-029 SHALL, while rst_n is low, force state to LOAD_A, row = col = 0, and all A and B elements to 0, immediately and independent of clk.
REQ-030 SHALL output in_ready = 1 and mat_valid = 0 during and after reset.
REQ-031 SHALL, on reset mid-load or in HOLD, discard all partial data; the first transfer after release writes A[0][0].

Structure
REQ-032 SHALL take the state enum (LOAD_A, LOAD_B, HOLD) from shared package matrix_pkg, together with the default MATRIX_SIZE and WORD_LENGTH constants used by the matrix datapath.
REQ-033 SHALL place the row/col counter in one sub-module, matrix_index_counter, with inputs advance and clear and outputs row, col and last.
REQ-034 SHALL connect A, B and mat_valid directly to the downstream multiplier's A, B and enable, with no extra pipeline stage.

Verification
REQ-035 SHALL cover: reset, then stream 1..18 with in_valid held high -> A = {1,2,3; 4,5,6; 7,8,9}, B = {10..18} row-major, mat_valid high on the cycle after the 18th transfer, in_ready low.
REQ-036 SHALL cover: in_valid toggled 1/0 every cycle across 18 elements -> same A and B as REQ-035; no element duplicated or lost.
REQ-037 SHALL cover: in HOLD with in_valid high and mat_ack low for 10 cycles -> A and B unchanged, in_ready = 0; then mat_ack pulse -> in_ready = 1 next cycle, and next element 99 lands in A[0][0].
REQ-038 SHALL cover: flush asserted together with the 5th transfer of B -> element dropped, state LOAD_A, and next element written to A[0][0].
REQ-039 SHALL cover: rst_n pulsed low asynchronously (mid-cycle) after 7 transfers -> A and B all 0, in_ready = 1, mat_valid = 0 before the next clk edge.
REQ-040 SHALL cover: MATRIX_SIZE = 1 build -> two transfers (5, 7) give A[0][0] = 5, B[0][0] = 7, and mat_valid high one cycle later.
